// File: rtl/crtc_reg_file_pkg.sv
// Shared constants and types for the CRTC register file and its address decode.
package crtc_reg_file_pkg;

  localparam int unsigned ADDR_W        = 17;
  localparam int unsigned PI_ADDR_W     = 16;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned IDX_W         = 5;
  localparam int unsigned CRTC_NUM_REGS = 18;

  localparam logic [ADDR_W-1:0]    CRTC_BASE    = 17'h0E880;
  localparam logic [PI_ADDR_W-1:0] CRTC_PI_BASE = 16'hE8F0;

  typedef logic [IDX_W-1:0] crtc_idx_t;

  // True when the index names an implemented register R0-R17.
  function automatic logic is_valid_idx(crtc_idx_t idx);
    return idx < IDX_W'(CRTC_NUM_REGS);
  endfunction

endpackage

// File: rtl/crtc_reg_file_if.sv
// CPU bus, Pi bus and video-side signals of the CRTC register file.
interface crtc_reg_file_if;
  import crtc_reg_file_pkg::*;

  logic [ADDR_W-1:0]    bus_addr;
  logic [DATA_W-1:0]    bus_data_in;
  logic                 cpu_write;
  logic [PI_ADDR_W-1:0] pi_addr;
  logic [DATA_W-1:0]    pi_data_in;
  logic                 pi_read;
  logic                 crtc_enable;
  logic [DATA_W-1:0]    crtc_data_out;
  logic                 crtc_data_out_enable;
  crtc_idx_t            crtc_address_register;
  logic [DATA_W-1:0]    crtc_r;

  modport master (
    output bus_addr, bus_data_in, cpu_write, pi_addr, pi_data_in, pi_read,
    input  crtc_enable, crtc_data_out, crtc_data_out_enable,
           crtc_address_register, crtc_r
  );

  modport slave (
    input  bus_addr, bus_data_in, cpu_write, pi_addr, pi_data_in, pi_read,
    output crtc_enable, crtc_data_out, crtc_data_out_enable,
           crtc_address_register, crtc_r
  );

endinterface

// File: rtl/crtc_addr_decode.sv
// CRTC chip select: $E880-$E8FF including mirrors.
module crtc_addr_decode
  import crtc_reg_file_pkg::*;
(
  input  logic [ADDR_W-1:0] bus_addr,
  output logic              crtc_enable
);

  // Low seven bits pick the register inside the window, not the window itself.
  logic [6:0] unused_low;
  assign unused_low = bus_addr[6:0];

  assign crtc_enable = (bus_addr[16:7] == CRTC_BASE[16:7]);

endmodule

// File: rtl/crtc_reg_file.sv
// CPU-visible 6545 CRTC register file with optional Pi read-back.
// Build option: define CRTC_PI_READ_EN to include the Pi read-back path.
module crtc_reg_file
  import crtc_reg_file_pkg::*;
(
  input logic            clk,
  input logic            reset,
  crtc_reg_file_if.slave bus
);

  logic [DATA_W-1:0] regs [CRTC_NUM_REGS];
  crtc_idx_t         addr_reg;
  logic              cpu_hit;

  crtc_addr_decode u_decode (
    .bus_addr    (bus.bus_addr),
    .crtc_enable (bus.crtc_enable)
  );

  assign cpu_hit                   = bus.cpu_write && bus.crtc_enable;
  assign bus.crtc_address_register = addr_reg;

  // Address register and R0-R17 updated by CPU writes; even selects address, odd selects data.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg <= '0;
      for (int i = 0; i < CRTC_NUM_REGS; i++) regs[i] <= '0;
    end else if (cpu_hit) begin
      if (!bus.bus_addr[0]) begin
        addr_reg <= bus.bus_data_in[IDX_W-1:0];
      end else if (is_valid_idx(addr_reg)) begin
        regs[addr_reg] <= bus.bus_data_in;
      end
    end
  end

  // Selected register to the video timing logic; unimplemented indices read zero.
  always_comb begin
    bus.crtc_r = '0;
    if (is_valid_idx(addr_reg)) bus.crtc_r = regs[addr_reg];
  end

`ifdef CRTC_PI_READ_EN
  logic [DATA_W-1:0] pi_data_q;
  logic              pi_valid_q;
  logic [DATA_W-1:0] unused_pi;

  assign unused_pi = bus.pi_data_in;

  // Pi read-back samples the pre-write register value; result holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      pi_data_q  <= '0;
      pi_valid_q <= 1'b0;
    end else if (bus.pi_read) begin
      if (bus.pi_addr[15:4] == CRTC_PI_BASE[15:4]) begin
        pi_data_q  <= regs[IDX_W'({1'b0, bus.pi_addr[3:0]})];
        pi_valid_q <= 1'b1;
      end else begin
        pi_valid_q <= 1'b0;
      end
    end
  end

  assign bus.crtc_data_out        = pi_data_q;
  assign bus.crtc_data_out_enable = pi_valid_q;
`else
  logic [PI_ADDR_W+DATA_W:0] unused_pi;

  assign unused_pi = {bus.pi_addr, bus.pi_data_in, bus.pi_read};

  assign bus.crtc_data_out        = '0;
  assign bus.crtc_data_out_enable = 1'b0;
`endif

endmodule

// File: tb/tb_crtc_reg_file.sv
// Directed self-checking bench for crtc_reg_file (either build of CRTC_PI_READ_EN).
module tb_crtc_reg_file;
  import crtc_reg_file_pkg::*;

`ifdef CRTC_PI_READ_EN
  localparam bit PI_EN = 1'b1;
`else
  localparam bit PI_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [7:0] exp_dout;
  logic       exp_den;

  crtc_reg_file_if bus ();

  crtc_reg_file u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [16:0] addr, input logic [7:0] data);
    bus.bus_addr    = addr;
    bus.bus_data_in = data;
    bus.cpu_write   = 1'b1;
    tick();
    bus.cpu_write   = 1'b0;
  endtask

  // Pi read; the bench model tracks what the outputs must show afterwards.
  task automatic pi_rd(input logic [15:0] addr, input logic [7:0] reg_val);
    bus.pi_addr = addr;
    bus.pi_read = 1'b1;
    tick();
    bus.pi_read = 1'b0;
    if (PI_EN) begin
      if (addr[15:4] == 12'hE8F) begin
        exp_dout = reg_val;
        exp_den  = 1'b1;
      end else begin
        exp_den  = 1'b0;
      end
    end
  endtask

  task automatic check_pi(input string tag);
    check({tag, "_data"}, bus.crtc_data_out, exp_dout);
    check({tag, "_en"}, 8'(bus.crtc_data_out_enable), 8'(exp_den));
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    exp_dout        = 8'h00;
    exp_den         = 1'b0;
    bus.bus_addr    = '0;
    bus.bus_data_in = '0;
    bus.cpu_write   = 1'b0;
    bus.pi_addr     = '0;
    bus.pi_data_in  = 8'hFF;
    bus.pi_read     = 1'b0;

    // Reset with a CPU write strobe active: reset must win.
    reset           = 1'b1;
    bus.bus_addr    = 17'h0E880;
    bus.bus_data_in = 8'h07;
    bus.cpu_write   = 1'b1;
    tick();
    tick();
    bus.cpu_write   = 1'b0;
    reset           = 1'b0;
    check("rst_addr", 8'(bus.crtc_address_register), 8'h00);
    check("rst_r", bus.crtc_r, 8'h00);
    check_pi("rst_pi");

    pi_rd(16'hE8F5, 8'h00);
    check_pi("pi_after_rst");
    check("addr_after_pi", 8'(bus.crtc_address_register), 8'h00);

    // R0-R15: select, store 80|r, read back by CPU view and Pi.
    for (int r = 0; r < 16; r++) begin
      cpu_wr(17'h0E880, 8'(r));
      check($sformatf("sel%0d", r), 8'(bus.crtc_address_register), 8'(r));
      cpu_wr(17'h0E881, 8'h80 | 8'(r));
      check($sformatf("r%0d", r), bus.crtc_r, 8'h80 | 8'(r));
      pi_rd(16'hE8F0 | 16'(r), 8'h80 | 8'(r));
      check_pi($sformatf("pi%0d", r));
      tick();
      check_pi($sformatf("pi%0d_hold", r));
    end

    cpu_wr(17'h0E880, 8'd16);
    cpu_wr(17'h0E881, 8'h90);
    check("r16", bus.crtc_r, 8'h90);
    cpu_wr(17'h0E880, 8'd17);
    cpu_wr(17'h0E881, 8'h91);
    check("r17", bus.crtc_r, 8'h91);

    // R20 is unimplemented: write discarded, reads zero.
    cpu_wr(17'h0E880, 8'd20);
    check("sel20", 8'(bus.crtc_address_register), 8'd20);
    cpu_wr(17'h0E881, 8'hAA);
    check("r20", bus.crtc_r, 8'h00);
    // Upper data bits do not leak into the 5-bit address register.
    cpu_wr(17'h0E880, 8'hE2);
    check("sel_mask", 8'(bus.crtc_address_register), 8'h02);
    for (int r = 0; r < 18; r++) begin
      cpu_wr(17'h0E880, 8'(r));
      check($sformatf("keep%0d", r), bus.crtc_r, (r < 16) ? (8'h80 | 8'(r)) : (8'h90 + 8'(r - 16)));
    end

    // Out-of-window writes are ignored.
    cpu_wr(17'h0E880, 8'd3);
    bus.bus_addr = 17'h0E780;
    #1 check("en_e780", 8'(bus.crtc_enable), 8'h00);
    cpu_wr(17'h0E780, 8'h07);
    check("addr_e780", 8'(bus.crtc_address_register), 8'd3);
    bus.bus_addr = 17'h0E901;
    #1 check("en_e901", 8'(bus.crtc_enable), 8'h00);
    cpu_wr(17'h0E901, 8'h11);
    check("r3_e901", bus.crtc_r, 8'h83);
    bus.bus_addr = 17'h1E880;
    #1 check("en_1e880", 8'(bus.crtc_enable), 8'h00);
    bus.bus_addr = 17'h0E8FF;
    #1 check("en_e8ff", 8'(bus.crtc_enable), 8'h01);

    pi_rd(16'hE800, 8'h00);
    check_pi("pi_e800");

    // Same-cycle CPU write of R3 and Pi read of R3: Pi sees the old value.
    bus.bus_addr    = 17'h0E881;
    bus.bus_data_in = 8'h55;
    bus.cpu_write   = 1'b1;
    pi_rd(16'hE8F3, 8'h83);
    bus.cpu_write   = 1'b0;
    check_pi("pi_race");
    check("r3_race", bus.crtc_r, 8'h55);
    pi_rd(16'hE8F3, 8'h55);
    check_pi("pi_after_race");

    // Mirror even address selects, mirror odd address writes.
    cpu_wr(17'h0E8FE, 8'd5);
    check("mirror_sel", 8'(bus.crtc_address_register), 8'd5);
    cpu_wr(17'h0E8A3, 8'h3C);
    check("mirror_wr", bus.crtc_r, 8'h3C);

    // Mid-sequence reset with both strobes active.
    reset           = 1'b1;
    bus.bus_addr    = 17'h0E881;
    bus.bus_data_in = 8'hEE;
    bus.cpu_write   = 1'b1;
    bus.pi_addr     = 16'hE8F5;
    bus.pi_read     = 1'b1;
    tick();
    reset           = 1'b0;
    bus.cpu_write   = 1'b0;
    bus.pi_read     = 1'b0;
    exp_dout        = 8'h00;
    exp_den         = 1'b0;
    check("rst2_addr", 8'(bus.crtc_address_register), 8'h00);
    check("rst2_r0", bus.crtc_r, 8'h00);
    check_pi("rst2_pi");
    cpu_wr(17'h0E880, 8'd5);
    check("rst2_r5", bus.crtc_r, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
